// File: rtl/booth_pkg.sv
// Shared definitions for the Booth radix-4 multiplier result path.
//   collect_state_t : states of the result collector
//   C_OUT_A/C_OUT_Q : control-word bit indices of the A/Q output strobes
//   multi_strobe()  : true when more than one collector strobe is asserted
package booth_pkg;

  typedef enum logic [1:0] {
    C_IDLE   = 2'd0,
    C_HAVE_A = 2'd1,
    C_HAVE_Q = 2'd2
  } collect_state_t;

  // Same bit positions the multiplier control unit drives onto c[].
  localparam int C_OUT_A = 6;
  localparam int C_OUT_Q = 7;

  function automatic logic multi_strobe(input logic a, input logic q, input logic d);
    return (a & q) | (a & d) | (q & d);
  endfunction

endpackage

// File: rtl/booth_result_fifo.sv
// Small first-word-fall-through FIFO holding committed products.
//   clk, rst_n : clock, synchronous active-low reset
//   push, din  : write request and data (accepted when not full, or when popping)
//   pop        : read request (ignored when empty)
//   dout       : head entry, registered; holds its last value when empty
//   valid      : FIFO non-empty
//   full       : FIFO holds DEPTH entries
//   level      : occupancy 0..DEPTH
module booth_result_fifo
  import booth_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_ptr_inc;
  logic [AW:0]      level_q;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dout_d;
  logic             empty;
  logic             pop_ok;
  logic             push_ok;

  assign empty      = (level_q == '0);
  assign full       = (level_q == FULL_LVL);
  assign pop_ok     = pop & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign push_ok    = push & (~full | pop_ok);
  assign rd_ptr_inc = rd_ptr_q + 1'b1;

  // Head register: keeps dout stable and glitch-free, and gives the
  // fall-through behaviour (a push into an empty FIFO shows up next cycle).
  always_comb begin
    dout_d = dout_q;
    if (pop_ok && (level_q > ONE_LVL)) begin
      dout_d = mem_q[rd_ptr_inc];
    end else if (push_ok && (empty || (pop_ok && (level_q == ONE_LVL)))) begin
      dout_d = din;
    end
  end

  // Storage array without reset so it maps onto plain RAM/registers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
    end else begin
      dout_q <= dout_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_inc;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + ONE_LVL;
        2'b01:   level_q <= level_q - ONE_LVL;
        default: level_q <= level_q;
      endcase
    end
  end

  assign dout  = dout_q;
  assign valid = ~empty;
  assign level = level_q;

endmodule

// File: rtl/booth_result_collector.sv
// Result collector for the Booth radix-4 multiplier. Snoops the shared result
// bus, captures A (high half) and Q (low half) on their strobes and commits
// {A,Q} into a small FIFO on the multiplier's stop pulse.
//   clk, rst_n   : clock, synchronous active-low reset
//   bus_in       : shared result bus, only sampled on a strobe
//   cap_a, cap_q : bus carries A / Q this cycle
//   done         : multiplier stop pulse, commits the captured product
//   prod_valid   : FIFO head holds a product
//   prod_ready   : consumer takes the head this cycle
//   product      : signed 2*WIDTH product {A,Q} at the FIFO head
//   level        : FIFO occupancy
//   busy         : partial product held
//   proto_err    : sticky strobe-order violation
//   overflow     : sticky, a commit was dropped because the FIFO was full
module booth_result_collector
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        bus_in,
  input  logic                    cap_a,
  input  logic                    cap_q,
  input  logic                    done,
  output logic                    prod_valid,
  input  logic                    prod_ready,
  output logic [2*WIDTH-1:0]      product,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    busy,
  output logic                    proto_err,
  output logic                    overflow
);

  collect_state_t   state_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             proto_err_q;
  logic             overflow_q;

  logic             multi;
  logic             commit;
  logic             pop;
  logic             fifo_full;

  assign multi  = multi_strobe(cap_a, cap_q, done);
  // Commit is decoded straight from the state so the product lands in the
  // FIFO on the done edge and is visible the following cycle.
  assign commit = (state_q == C_HAVE_Q) & done & ~multi;
  assign pop    = prod_valid & prod_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= C_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      proto_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (commit && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
      if (multi) begin
        // Conflicting strobes: flag, but leave state and data untouched.
        proto_err_q <= 1'b1;
      end else begin
        case (state_q)
          C_IDLE: begin
            if (cap_a) begin
              hi_q    <= bus_in;
              state_q <= C_HAVE_A;
            end else if (cap_q || done) begin
              proto_err_q <= 1'b1;
            end
          end
          C_HAVE_A: begin
            if (cap_q) begin
              lo_q    <= bus_in;
              state_q <= C_HAVE_Q;
            end else if (cap_a) begin
              hi_q        <= bus_in;
              proto_err_q <= 1'b1;
            end else if (done) begin
              proto_err_q <= 1'b1;
              state_q     <= C_IDLE;
            end
          end
          C_HAVE_Q: begin
            if (done) begin
              state_q <= C_IDLE;
            end else if (cap_a) begin
              // A new result started before the old one was committed.
              hi_q        <= bus_in;
              proto_err_q <= 1'b1;
              state_q     <= C_HAVE_A;
            end else if (cap_q) begin
              lo_q        <= bus_in;
              proto_err_q <= 1'b1;
            end
          end
          default: state_q <= C_IDLE;
        endcase
      end
    end
  end

  booth_result_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (commit),
    .pop   (pop),
    .din   ({hi_q, lo_q}),
    .dout  (product),
    .valid (prod_valid),
    .full  (fifo_full),
    .level (level)
  );

  assign busy      = (state_q != C_IDLE);
  assign proto_err = proto_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_booth_result_collector.sv
module tb_booth_result_collector;

  logic        clk;
  logic        rst_n;
  logic [7:0]  bus_in;
  logic        cap_a;
  logic        cap_q;
  logic        done;
  logic        prod_valid;
  logic        prod_ready;
  logic [15:0] product;
  logic [1:0]  level;
  logic        busy;
  logic        proto_err;
  logic        overflow;

  int checks = 0;
  int passes = 0;

  booth_result_collector #(.WIDTH(8), .DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_in     (bus_in),
    .cap_a      (cap_a),
    .cap_q      (cap_q),
    .done       (done),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .product    (product),
    .level      (level),
    .busy       (busy),
    .proto_err  (proto_err),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are read 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One clean A/Q/done sequence; prod_ready is only r_done in the done cycle.
  task automatic send(input logic [7:0] a, input logic [7:0] q, input logic r_done);
    prod_ready = 1'b0;
    bus_in = a; cap_a = 1'b1; cyc(); cap_a = 1'b0;
    bus_in = q; cap_q = 1'b1; cyc(); cap_q = 1'b0;
    bus_in = 8'h00; done = 1'b1; prod_ready = r_done; cyc(); done = 1'b0;
    prod_ready = 1'b0;
    $display("send A=%h Q=%h -> head=%h level=%0d", a, q, product, level);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cyc(); cyc(); rst_n = 1'b1;
    checks++; if (prod_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", prod_valid); else passes++;
    checks++; if (product !== 16'h0000) $display("FAIL rst_product: got %h want 0000", product); else passes++;
    checks++; if (level !== 2'd0) $display("FAIL rst_level: got %0d want 0", level); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passes++;
    checks++; if (proto_err !== 1'b0) $display("FAIL rst_proto: got %b want 0", proto_err); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", overflow); else passes++;
  endtask

  task automatic test_normal();
    prod_ready = 1'b1;
    bus_in = 8'hFF; cap_a = 1'b1; cyc(); cap_a = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL norm_busy: got %b want 1", busy); else passes++;
    bus_in = 8'hF4; cap_q = 1'b1; cyc(); cap_q = 1'b0;
    checks++; if (prod_valid !== 1'b0) $display("FAIL norm_early_valid: got %b want 0", prod_valid); else passes++;
    done = 1'b1; cyc(); done = 1'b0;
    checks++; if (prod_valid !== 1'b1) $display("FAIL norm_valid: got %b want 1", prod_valid); else passes++;
    checks++; if (product !== 16'hFFF4) $display("FAIL norm_product: got %h want fff4", product); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL norm_idle: got %b want 0", busy); else passes++;
    $display("normal product=%h", product);
    cyc();
    checks++; if (level !== 2'd0) $display("FAIL norm_drain: got %0d want 0", level); else passes++;
    checks++; if (proto_err !== 1'b0) $display("FAIL norm_proto: got %b want 0", proto_err); else passes++;
    prod_ready = 1'b0;
  endtask

  task automatic test_full_simul();
    send(8'h00, 8'h11, 1'b0);
    send(8'h00, 8'h22, 1'b0);
    checks++; if (level !== 2'd2) $display("FAIL fs_fill: got %0d want 2", level); else passes++;
    send(8'h00, 8'h33, 1'b1);
    checks++; if (level !== 2'd2) $display("FAIL fs_level: got %0d want 2", level); else passes++;
    checks++; if (product !== 16'h0022) $display("FAIL fs_head: got %h want 0022", product); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL fs_ovf: got %b want 0", overflow); else passes++;
    prod_ready = 1'b1; cyc();
    checks++; if (product !== 16'h0033) $display("FAIL fs_next: got %h want 0033", product); else passes++;
    cyc(); prod_ready = 1'b0;
    checks++; if (level !== 2'd0) $display("FAIL fs_empty: got %0d want 0", level); else passes++;
  endtask

  task automatic test_backpressure();
    send(8'h00, 8'h06, 1'b0);
    checks++; if (level !== 2'd1) $display("FAIL bp_level1: got %0d want 1", level); else passes++;
    send(8'h01, 8'h90, 1'b0);
    send(8'hFF, 8'h38, 1'b0);
    checks++; if (level !== 2'd2) $display("FAIL bp_level2: got %0d want 2", level); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL bp_ovf: got %b want 1", overflow); else passes++;
    checks++; if (product !== 16'h0006) $display("FAIL bp_first: got %h want 0006", product); else passes++;
    prod_ready = 1'b1; cyc();
    checks++; if (product !== 16'h0190) $display("FAIL bp_second: got %h want 0190", product); else passes++;
    checks++; if (level !== 2'd1) $display("FAIL bp_after_pop: got %0d want 1", level); else passes++;
    cyc(); prod_ready = 1'b0;
    checks++; if (prod_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", prod_valid); else passes++;
  endtask

  task automatic test_protocol();
    checks++; if (proto_err !== 1'b0) $display("FAIL pe_clean: got %b want 0", proto_err); else passes++;
    bus_in = 8'h55; cap_q = 1'b1; cyc(); cap_q = 1'b0;
    checks++; if (proto_err !== 1'b1) $display("FAIL pe_q_first: got %b want 1", proto_err); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL pe_q_idle: got %b want 0", busy); else passes++;
    checks++; if (level !== 2'd0) $display("FAIL pe_q_nocommit: got %0d want 0", level); else passes++;
    bus_in = 8'h12; cap_a = 1'b1; cyc();
    bus_in = 8'h99; cap_q = 1'b1; cyc(); cap_a = 1'b0; cap_q = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL pe_dual_hold: got %b want 1", busy); else passes++;
    bus_in = 8'h34; cap_q = 1'b1; cyc(); cap_q = 1'b0;
    done = 1'b1; cyc(); done = 1'b0;
    checks++; if (product !== 16'h1234) $display("FAIL pe_dual_data: got %h want 1234", product); else passes++;
    bus_in = 8'h77; cap_a = 1'b1; cyc(); cap_a = 1'b0;
    done = 1'b1; cyc(); done = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL pe_done_a_idle: got %b want 0", busy); else passes++;
    checks++; if (level !== 2'd1) $display("FAIL pe_done_a_nopush: got %0d want 1", level); else passes++;
    prod_ready = 1'b1; cyc(); prod_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    send(8'h00, 8'h01, 1'b0);
    bus_in = 8'hAB; cap_a = 1'b1; cyc(); cap_a = 1'b0;
    bus_in = 8'hCD; cap_q = 1'b1; cyc(); cap_q = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL rm_have_q: got %b want 1", busy); else passes++;
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    checks++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else passes++;
    checks++; if (level !== 2'd0) $display("FAIL rm_level: got %0d want 0", level); else passes++;
    checks++; if (prod_valid !== 1'b0) $display("FAIL rm_valid: got %b want 0", prod_valid); else passes++;
    checks++; if (proto_err !== 1'b0) $display("FAIL rm_proto: got %b want 0", proto_err); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL rm_ovf: got %b want 0", overflow); else passes++;
    send(8'h00, 8'h2A, 1'b0);
    checks++; if (product !== 16'h002A) $display("FAIL rm_clean: got %h want 002a", product); else passes++;
    checks++; if (prod_valid !== 1'b1) $display("FAIL rm_clean_valid: got %b want 1", prod_valid); else passes++;
    prod_ready = 1'b1; cyc(); prod_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    logic [7:0]  a_v;
    logic [7:0]  q_v;
    int sent = 0;
    int got  = 0;
    int c    = 0;
    while ((sent < 10 || got < 10) && c < 200) begin
      a_v = 8'(sent * 19);
      q_v = 8'(8'hF0 + sent);
      cap_a = 1'b0; cap_q = 1'b0; done = 1'b0; bus_in = 8'h00;
      if (sent < 10) begin
        case (c % 3)
          0: begin cap_a = 1'b1; bus_in = a_v; end
          1: begin cap_q = 1'b1; bus_in = q_v; end
          default: done = 1'b1;
        endcase
        prod_ready = c[0];
      end else begin
        prod_ready = 1'b1;
      end
      if (prod_valid && prod_ready) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
        checks++;
        if (product !== exp_v) $display("FAIL wrap_pop%0d: got %h want %h", got, product, exp_v);
        else passes++;
        $display("wrap pop %0d product=%h", got, product);
        got++;
      end
      if (done) begin
        exp_q.push_back({a_v, q_v});
        sent++;
      end
      cyc();
      c++;
    end
    cap_a = 1'b0; cap_q = 1'b0; done = 1'b0; prod_ready = 1'b0;
    checks++; if (got !== 10) $display("FAIL wrap_count: got %0d want 10", got); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL wrap_ovf: got %b want 0", overflow); else passes++;
    checks++; if (level !== 2'd0) $display("FAIL wrap_level: got %0d want 0", level); else passes++;
  endtask

  initial begin
    rst_n = 1'b0; bus_in = 8'h00; cap_a = 1'b0; cap_q = 1'b0;
    done = 1'b0; prod_ready = 1'b0;
    test_reset();
    test_normal();
    test_full_simul();
    test_backpressure();
    test_protocol();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
